// File: rtl/dmem_responder.sv
// Data-memory responder for the pipelined MIPS core: word RAM plus a small MMIO window
// (GPIO, cycle counter, timer compare, sticky status, done). Loads are combinational.
module dmem_responder #(
  parameter int unsigned DEPTH_WORDS = 64,
  parameter logic [31:0] MMIO_BASE   = 32'hFFFF_0000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        memwriteM,
  input  logic        sbM,
  input  logic [31:0] aluoutM,
  input  logic [31:0] writedataM,
  output logic [31:0] readdataM,
  output logic [31:0] gpio_out,
  output logic        timer_irq,
  output logic        addr_err,
  output logic        done
);

  localparam int unsigned IDX_W     = $clog2(DEPTH_WORDS);
  localparam logic [31:0] RAM_BYTES = DEPTH_WORDS * 4;

  localparam logic [15:0] OFF_GPIO   = 16'h0000;
  localparam logic [15:0] OFF_CYCLE  = 16'h0004;
  localparam logic [15:0] OFF_TCMP   = 16'h0008;
  localparam logic [15:0] OFF_STATUS = 16'h000C;
  localparam logic [15:0] OFF_DONE   = 16'h0010;

  // RAM storage (not reset)
  logic [31:0] mem_q [DEPTH_WORDS];

  // MMIO state
  logic [31:0] gpio_q, gpio_d;
  logic [31:0] cycle_q, cycle_d;
  logic [31:0] tcmp_q, tcmp_d;
  logic        irq_q, irq_d;
  logic        err_q, err_d;
  logic        done_q, done_d;

  // Address decode
  logic             sel_ram;
  logic             in_window;
  logic [15:0]      offset;
  logic             sel_gpio, sel_cycle, sel_tcmp, sel_status, sel_done;
  logic             sel_mmio;
  logic [IDX_W-1:0] idx;
  logic [1:0]       lane;

  assign idx    = aluoutM[IDX_W+1:2];
  assign lane   = aluoutM[1:0];
  assign offset = aluoutM[15:0];

  always_comb begin
    sel_ram    = (aluoutM < RAM_BYTES);
    in_window  = (aluoutM[31:16] == MMIO_BASE[31:16]) && !sel_ram;
    sel_gpio   = in_window && (offset == OFF_GPIO);
    sel_cycle  = in_window && (offset == OFF_CYCLE);
    sel_tcmp   = in_window && (offset == OFF_TCMP);
    sel_status = in_window && (offset == OFF_STATUS);
    sel_done   = in_window && (offset == OFF_DONE);
    sel_mmio   = sel_gpio | sel_cycle | sel_tcmp | sel_status | sel_done;
  end

  // Store classification
  logic ram_we;
  logic mmio_we;
  logic err_set;
  logic misaligned;

  always_comb begin
    misaligned = (lane != 2'b00);
    ram_we     = memwriteM && sel_ram && (sbM || !misaligned);
    mmio_we    = memwriteM && sel_mmio && !sbM;
    err_set    = memwriteM && ((sel_ram && !sbM && misaligned) ||
                               (sel_mmio && sbM) ||
                               (!sel_ram && !sel_mmio));
  end

  // Byte stores merge into the current word so one write port serves both sizes
  logic [31:0] ram_wdata;

  always_comb begin
    ram_wdata = mem_q[idx];
    if (sbM) begin
      ram_wdata[{lane, 3'b000} +: 8] = writedataM[7:0];
    end else begin
      ram_wdata = writedataM;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (reset && ram_we) begin
      mem_q[idx] <= ram_wdata;
    end
  end

  // MMIO next state
  logic timer_hit;
  logic clr_irq;
  logic clr_err;

  always_comb begin
    timer_hit = (tcmp_q != 32'd0) && (cycle_q == tcmp_q);
    clr_irq   = mmio_we && sel_status && writedataM[0];
    clr_err   = mmio_we && sel_status && writedataM[1];

    gpio_d  = gpio_q;
    tcmp_d  = tcmp_q;
    cycle_d = cycle_q + 32'd1;
    done_d  = done_q;

    if (mmio_we && sel_gpio) begin
      gpio_d = writedataM;
    end
    if (mmio_we && sel_tcmp) begin
      tcmp_d = writedataM;
    end
    if (mmio_we && sel_done) begin
      done_d = 1'b1;
    end

    // Set beats W1C when both happen in the same cycle
    irq_d = (irq_q && !clr_irq) || timer_hit;
    err_d = (err_q && !clr_err) || err_set;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      gpio_q  <= 32'd0;
      cycle_q <= 32'd0;
      tcmp_q  <= 32'd0;
      irq_q   <= 1'b0;
      err_q   <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      gpio_q  <= gpio_d;
      cycle_q <= cycle_d;
      tcmp_q  <= tcmp_d;
      irq_q   <= irq_d;
      err_q   <= err_d;
      done_q  <= done_d;
    end
  end

  // Load path
  logic [31:0] status_word;

  always_comb begin
    status_word = {29'd0, done_q, err_q, irq_q};
    readdataM   = 32'd0;
    if (sel_ram) begin
      readdataM = mem_q[idx];
    end else if (sel_gpio) begin
      readdataM = gpio_q;
    end else if (sel_cycle) begin
      readdataM = cycle_q;
    end else if (sel_tcmp) begin
      readdataM = tcmp_q;
    end else if (sel_status) begin
      readdataM = status_word;
    end else if (sel_done) begin
      readdataM = {29'd0, done_q, 2'b00};
    end
  end

  assign gpio_out  = gpio_q;
  assign timer_irq = irq_q;
  assign addr_err  = err_q;
  assign done      = done_q;

endmodule

// File: tb/tb_dmem_responder.sv
// Bench for dmem_responder: directed vector table, hand-written reset/timer sequences,
// then random traffic checked against a behavioural model of the memory map.
module tb_dmem_responder;

  logic        clk = 1'b0;
  logic        reset;
  logic        memwriteM;
  logic        sbM;
  logic [31:0] aluoutM;
  logic [31:0] writedataM;
  logic [31:0] readdataM;
  logic [31:0] gpio_out;
  logic        timer_irq;
  logic        addr_err;
  logic        done;

  dmem_responder dut (
    .clk       (clk),
    .reset     (reset),
    .memwriteM (memwriteM),
    .sbM       (sbM),
    .aluoutM   (aluoutM),
    .writedataM(writedataM),
    .readdataM (readdataM),
    .gpio_out  (gpio_out),
    .timer_irq (timer_irq),
    .addr_err  (addr_err),
    .done      (done)
  );

  always #5 clk = ~clk;

  int unsigned n_vec = 0;
  int unsigned n_bad = 0;

  // Behavioural model
  logic [31:0] m_ram [64];
  logic [3:0]  m_vld [64];
  logic [31:0] m_gpio, m_cycle, m_tcmp;
  logic        m_irq, m_err, m_done;

  typedef struct {
    logic        we;
    logic        sb;
    logic [31:0] a;
    logic [31:0] wd;
    logic        chk;
    logic [31:0] exp;
  } vec_t;

  vec_t tbl[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  task automatic model_reset();
    m_gpio  = 32'd0;
    m_cycle = 32'd0;
    m_tcmp  = 32'd0;
    m_irq   = 1'b0;
    m_err   = 1'b0;
    m_done  = 1'b0;
  endtask

  function automatic logic [31:0] model_read(input logic [31:0] a, output logic [31:0] mask);
    int w;
    mask = 32'hFFFF_FFFF;
    model_read = 32'd0;
    if (a < 32'd256) begin
      w = int'(a / 4);
      model_read = m_ram[w];
      mask = {{8{m_vld[w][3]}}, {8{m_vld[w][2]}}, {8{m_vld[w][1]}}, {8{m_vld[w][0]}}};
    end else if (a[31:16] == 16'hFFFF) begin
      case (a[15:0])
        16'h0000: model_read = m_gpio;
        16'h0004: model_read = m_cycle;
        16'h0008: model_read = m_tcmp;
        16'h000C: model_read = {29'd0, m_done, m_err, m_irq};
        16'h0010: mask = 32'd0;
        default:  model_read = 32'd0;
      endcase
    end
  endfunction

  // Apply the rules of one clock edge to the model using the inputs now driven
  task automatic model_edge();
    logic        tset, err, c0, c1, mm;
    logic [31:0] a, wd;
    logic [15:0] off;
    int          w, ln;
    a    = aluoutM;
    wd   = writedataM;
    off  = a[15:0];
    tset = (m_tcmp != 0) && (m_cycle == m_tcmp);
    err  = 1'b0;
    c0   = 1'b0;
    c1   = 1'b0;
    mm   = (a[31:16] == 16'hFFFF) &&
           (off == 16'h0 || off == 16'h4 || off == 16'h8 || off == 16'hC || off == 16'h10);
    if (memwriteM) begin
      if (a < 32'd256) begin
        w  = int'(a / 4);
        ln = int'(a % 4);
        if (sbM) begin
          m_ram[w][ln*8 +: 8] = wd[7:0];
          m_vld[w][ln] = 1'b1;
        end else if (ln == 0) begin
          m_ram[w] = wd;
          m_vld[w] = 4'hF;
        end else begin
          err = 1'b1;
        end
      end else if (mm) begin
        if (sbM) err = 1'b1;
        else begin
          case (off)
            16'h0:   m_gpio = wd;
            16'h8:   m_tcmp = wd;
            16'hC:   begin c0 = wd[0]; c1 = wd[1]; end
            16'h10:  m_done = 1'b1;
            default: ;
          endcase
        end
      end else begin
        err = 1'b1;
      end
    end
    m_irq   = (m_irq && !c0) || tset;
    m_err   = (m_err && !c1) || err;
    m_cycle = m_cycle + 1;
  endtask

  task automatic apply(input logic we, input logic sb, input logic [31:0] a,
                       input logic [31:0] wd);
    logic [31:0] exp, mask;
    @(negedge clk);
    memwriteM  = we;
    sbM        = sb;
    aluoutM    = a;
    writedataM = wd;
    #1;
    exp = model_read(a, mask);
    if (mask != 32'd0) check("readdata", readdataM & mask, exp & mask);
    check("gpio_out", gpio_out, m_gpio);
    check("timer_irq", {31'd0, timer_irq}, {31'd0, m_irq});
    check("addr_err", {31'd0, addr_err}, {31'd0, m_err});
    check("done", {31'd0, done}, {31'd0, m_done});
  endtask

  task automatic tick();
    @(posedge clk);
    model_edge();
  endtask

  // Asynchronous reset between edges, then release on a falling edge
  task automatic pulse_reset(input logic store_in_reset);
    @(negedge clk);
    memwriteM = 1'b0;
    aluoutM   = 32'hFFFF_0004;
    #2;
    reset = 1'b0;
    #1;
    model_reset();
    check("rst_cycle_rd", readdataM, 32'd0);
    check("rst_gpio", gpio_out, 32'd0);
    check("rst_flags", {29'd0, done, addr_err, timer_irq}, 32'd0);
    if (store_in_reset) begin
      memwriteM  = 1'b1;
      sbM        = 1'b0;
      aluoutM    = 32'h10;
      writedataM = 32'h1234_5678;
    end
    @(posedge clk);
    @(negedge clk);
    memwriteM = 1'b0;
    reset     = 1'b1;
    tick();
  endtask

  initial begin
    logic [31:0] a, wd;
    int          r;

    reset      = 1'b0;
    memwriteM  = 1'b0;
    sbM        = 1'b0;
    aluoutM    = 32'd0;
    writedataM = 32'd0;
    for (int i = 0; i < 64; i++) begin
      m_ram[i] = 32'd0;
      m_vld[i] = 4'h0;
    end
    model_reset();

    tbl.push_back('{1'b1, 1'b0, 32'h0000_0010, 32'hDEAD_BEEF, 1'b0, 32'h0});
    tbl.push_back('{1'b0, 1'b0, 32'h0000_0010, 32'h0,         1'b1, 32'hDEAD_BEEF});
    tbl.push_back('{1'b1, 1'b0, 32'h0000_0010, 32'hCAFE_F00D, 1'b1, 32'hDEAD_BEEF});
    tbl.push_back('{1'b0, 1'b0, 32'h0000_0010, 32'h0,         1'b1, 32'hCAFE_F00D});
    tbl.push_back('{1'b1, 1'b0, 32'h0000_0020, 32'h1122_3344, 1'b0, 32'h0});
    tbl.push_back('{1'b1, 1'b1, 32'h0000_0022, 32'h1234_56AA, 1'b1, 32'h1122_3344});
    tbl.push_back('{1'b0, 1'b0, 32'h0000_0020, 32'h0,         1'b1, 32'h11AA_3344});
    tbl.push_back('{1'b1, 1'b0, 32'h0000_0021, 32'h9999_9999, 1'b1, 32'h11AA_3344});
    tbl.push_back('{1'b0, 1'b0, 32'h0000_0020, 32'h0,         1'b1, 32'h11AA_3344});
    tbl.push_back('{1'b0, 1'b0, 32'hFFFF_000C, 32'h0,         1'b1, 32'h0000_0002});
    tbl.push_back('{1'b1, 1'b0, 32'hFFFF_0000, 32'h0000_0005, 1'b1, 32'h0});
    tbl.push_back('{1'b0, 1'b0, 32'hFFFF_0000, 32'h0,         1'b1, 32'h0000_0005});
    tbl.push_back('{1'b1, 1'b0, 32'hFFFF_0010, 32'h0000_0000, 1'b0, 32'h0});
    tbl.push_back('{1'b0, 1'b0, 32'hFFFF_000C, 32'h0,         1'b1, 32'h0000_0006});
    tbl.push_back('{1'b1, 1'b0, 32'hFFFF_000C, 32'h0000_0007, 1'b1, 32'h0000_0006});
    tbl.push_back('{1'b0, 1'b0, 32'hFFFF_000C, 32'h0,         1'b1, 32'h0000_0004});
    tbl.push_back('{1'b0, 1'b0, 32'h8000_0000, 32'h0,         1'b1, 32'h0});
    tbl.push_back('{1'b1, 1'b0, 32'h8000_0000, 32'h0000_1234, 1'b1, 32'h0});
    tbl.push_back('{1'b0, 1'b0, 32'hFFFF_000C, 32'h0,         1'b1, 32'h0000_0006});
    tbl.push_back('{1'b1, 1'b1, 32'hFFFF_0000, 32'h0000_00FF, 1'b1, 32'h0000_0005});
    tbl.push_back('{1'b0, 1'b0, 32'hFFFF_0000, 32'h0,         1'b1, 32'h0000_0005});
    tbl.push_back('{1'b0, 1'b0, 32'hFFFF_0002, 32'h0,         1'b1, 32'h0});
    tbl.push_back('{1'b0, 1'b0, 32'hFFFF_0008, 32'h0,         1'b1, 32'h0});

    // Reset state, observed while reset is held
    #3;
    check("reset_gpio", gpio_out, 32'd0);
    check("reset_flags", {29'd0, done, addr_err, timer_irq}, 32'd0);
    aluoutM = 32'hFFFF_0004;
    #1;
    check("reset_cycle", readdataM, 32'd0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 1'b1;
    tick();

    foreach (tbl[i]) begin
      apply(tbl[i].we, tbl[i].sb, tbl[i].a, tbl[i].wd);
      if (tbl[i].chk) check($sformatf("tbl%0d_rd", i), readdataM, tbl[i].exp);
      tick();
    end
    apply(1'b0, 1'b0, 32'h0, 32'h0);
    check("tbl_gpio_out", gpio_out, 32'h5);
    check("tbl_done", {31'd0, done}, 32'd1);
    tick();

    // Mid-run reset; store issued while reset is low must be dropped
    pulse_reset(1'b1);
    apply(1'b0, 1'b0, 32'h10, 32'h0);
    check("ram_kept_in_reset", readdataM, 32'hCAFE_F00D);
    tick();

    // Timer match, with W1C landing on the exact set cycle
    apply(1'b1, 1'b0, 32'hFFFF_0008, 32'd20);
    tick();
    while (m_cycle < 32'd26) begin
      if (m_cycle == 32'd20) begin
        apply(1'b1, 1'b0, 32'hFFFF_000C, 32'h1);
        check("irq_before_match", {31'd0, timer_irq}, 32'd0);
      end else begin
        apply(1'b0, 1'b0, 32'hFFFF_0004, 32'h0);
      end
      tick();
    end
    apply(1'b0, 1'b0, 32'hFFFF_000C, 32'h0);
    check("irq_set_wins", {31'd0, timer_irq}, 32'd1);
    tick();

    // Timer disabled
    apply(1'b1, 1'b0, 32'hFFFF_0008, 32'd0);
    tick();
    apply(1'b1, 1'b0, 32'hFFFF_000C, 32'h3);
    tick();
    repeat (40) begin
      apply(1'b0, 1'b0, 32'hFFFF_0004, 32'h0);
      tick();
    end
    check("irq_disabled", {31'd0, timer_irq}, 32'd0);

    // CYCLE is read-only
    apply(1'b1, 1'b0, 32'hFFFF_0004, 32'hFFFF_FFF0);
    tick();
    apply(1'b0, 1'b0, 32'hFFFF_0004, 32'h0);
    check("cycle_ro", readdataM, m_cycle);
    tick();

    // Random traffic
    for (int it = 0; it < 3000; it++) begin
      if (it % 700 == 699) pulse_reset(1'b0);
      r  = int'($urandom_range(0, 9));
      wd = $urandom;
      case (r)
        0, 1, 2, 3, 8, 9: a = $urandom_range(0, 255);
        4: begin
          case ($urandom_range(0, 5))
            0:       a = 32'hFFFF_0000;
            1:       a = 32'hFFFF_0004;
            2:       a = 32'hFFFF_0008;
            3:       a = 32'hFFFF_000C;
            4:       a = 32'hFFFF_0010;
            default: a = 32'hFFFF_0000 | $urandom_range(0, 31);
          endcase
        end
        5: a = $urandom | 32'h0001_0000;
        6: begin
          a  = 32'hFFFF_0008;
          wd = m_cycle + $urandom_range(1, 6);
        end
        default: a = 32'hFFFF_000C;
      endcase
      if (r >= 8) apply(1'b0, 1'($urandom_range(0, 1)), a, wd);
      else if (r >= 6) apply(1'b1, 1'b0, a, wd);
      else apply(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), a, wd);
      tick();
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
